// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller. Accepts one {addr,data} request and shifts out a
// 16-bit write frame {1'b1, addr[6:0], data[7:0]} MSB first, with chip-select setup,
// hold and inter-frame gap timing sized for a peripheral with 2-flop input synchronisers.
module spi_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned CS_GAP   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       ncs,
  output logic       copi
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be >= 2");
  end
  if (CS_SETUP < 1 || CS_HOLD < 1 || CS_GAP < 1) begin : g_bad_cs_timing
    $error("spi_controller: CS_SETUP, CS_HOLD and CS_GAP must be >= 1");
  end

  // One shared phase counter covers the longest of the timed intervals.
  localparam int unsigned Max1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned Max2   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int unsigned CntMax = (Max1 > Max2) ? Max1 : Max2;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(CS_GAP - 1);
  localparam logic [4:0]      NumBits   = 5'd16;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  // Bit 15 goes straight to copi at accept, so only bits 14..0 are kept here.
  logic [14:0]     shift_q, shift_d;
  logic            sclk_q, sclk_d;
  logic            ncs_q, ncs_d;
  logic            copi_q, copi_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [15:0]     frame;

  assign frame = {1'b1, req_addr, req_data};

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sclk_d    = sclk_q;
    ncs_d     = ncs_q;
    copi_d    = copi_q;
    done_d    = 1'b0;
    busy_d    = busy_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StSetup;
          cnt_d   = '0;
          shift_d = frame[14:0];
          ncs_d   = 1'b0;
          sclk_d  = 1'b0;
          copi_d  = frame[15];
          busy_d  = 1'b1;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d   = StShift;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // End of low phase: rising edge, count it (saturates at 16).
            sclk_d = 1'b1;
            if (bit_cnt_q != NumBits) begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else if (bit_cnt_q == NumBits) begin
            // Last falling edge: copi keeps bit 0 through HOLD.
            sclk_d  = 1'b0;
            state_d = StHold;
          end else begin
            // Falling edge: present the next bit at the start of the low phase.
            sclk_d  = 1'b0;
            copi_d  = shift_q[14];
            shift_d = {shift_q[13:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StGap;
          cnt_d   = '0;
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      copi_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      copi_q    <= copi_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = busy_q;
  assign done      = done_q;
  assign sclk      = sclk_q;
  assign ncs       = ncs_q;
  assign copi      = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: directed and random frames on a default instance, plus a
// CLK_DIV=2 instance, checked against frame/timing expectations computed from the rules.
`define CHK(tag, obs, exp) \
  begin \
    total++; \
    assert ((obs) === (exp)) passes++; \
    else $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
  end

module tb_spi_controller;

  localparam int unsigned Div      = 4;
  localparam int unsigned Setup    = 4;
  localparam int unsigned Hold     = 4;
  localparam int unsigned Gap      = 8;
  localparam int unsigned DivB     = 2;
  localparam int unsigned NcsRise  = 1 + Setup + 32 * Div + Hold;
  localparam int unsigned ReadyRet = NcsRise + Gap;
  localparam int unsigned NcsRiseB = 1 + Setup + 32 * DivB + Hold;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_valid_b;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       req_ready_a, busy_a, done_a, sclk_a, ncs_a, copi_a;
  logic       req_ready_b, busy_b, done_b, sclk_b, ncs_b, copi_b;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;
  int t0, t0b, prev_rise;

  logic [15:0] rx_a = '0;
  logic [15:0] rx_b = '0;
  int rises_a = 0, rises_b = 0, dones_a = 0, viol_a = 0;
  int rise_cyc_a = 0, fall_cyc_a = 0, rise_cyc_b = 0;
  int run_b = 0, bad_b = 0;
  logic last_b = 1'b0;

  spi_controller #(
    .CLK_DIV(Div), .CS_SETUP(Setup), .CS_HOLD(Hold), .CS_GAP(Gap)
  ) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_addr(req_addr), .req_data(req_data), .busy(busy_a), .done(done_a),
    .sclk(sclk_a), .ncs(ncs_a), .copi(copi_a)
  );

  spi_controller #(
    .CLK_DIV(DivB), .CS_SETUP(Setup), .CS_HOLD(Hold), .CS_GAP(Gap)
  ) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr), .req_data(req_data), .busy(busy_b), .done(done_b),
    .sclk(sclk_b), .ncs(ncs_b), .copi(copi_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Peripheral-side view: sample copi on each sclk rise.
  always @(posedge sclk_a) begin
    rx_a = {rx_a[14:0], copi_a};
    rises_a++;
  end
  always @(posedge sclk_b) begin
    rx_b = {rx_b[14:0], copi_b};
    rises_b++;
  end
  always @(posedge ncs_a) rise_cyc_a = cyc;
  always @(negedge ncs_a) fall_cyc_a = cyc;
  always @(posedge ncs_b) rise_cyc_b = cyc;
  always @(negedge clk) if (done_a) dones_a++;
  always @(copi_a) if (sclk_a) viol_a++;

  // Phase-length watcher for the CLK_DIV=2 instance.
  always @(negedge clk) begin
    if (sclk_b == last_b) begin
      run_b++;
    end else begin
      if (last_b && run_b != DivB) bad_b++;
      if (!last_b && rises_b >= 2 && run_b != DivB) bad_b++;
      run_b  = 1;
      last_b = sclk_b;
    end
  end

  function automatic logic [15:0] model(input logic [6:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [6:0] a, input logic [7:0] d, input bit hold);
    int n;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready_a && n < 1000) begin
      step();
      n++;
    end
    `CHK("accept_wait", req_ready_a, 1'b1)
    t0      = cyc;
    rx_a    = '0;
    rises_a = 0;
    dones_a = 0;
    step();
    if (!hold) req_valid = 1'b0;
    `CHK("busy_after_accept", busy_a, 1'b1)
  endtask

  task automatic finish_check(input logic [15:0] exp_frame);
    int n;
    n = 0;
    while (!req_ready_a && n < 1000) begin
      step();
      n++;
    end
    `CHK("ready_wait", req_ready_a, 1'b1)
    `CHK("frame", rx_a, exp_frame)
    `CHK("rises", rises_a, 16)
    `CHK("done_pulses", dones_a, 1)
    `CHK("ncs_rise_cycle", rise_cyc_a - t0, NcsRise)
    `CHK("ready_cycle", cyc - t0, ReadyRet)
  endtask

  initial begin
    logic [6:0] a;
    logic [7:0] d;
    int n;

    // Reset
    rst = 1'b1; req_valid = 1'b0; req_valid_b = 1'b0; req_addr = '0; req_data = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    `CHK("rst_ncs", ncs_a, 1'b1)
    `CHK("rst_sclk", sclk_a, 1'b0)
    `CHK("rst_copi", copi_a, 1'b0)
    `CHK("rst_done", done_a, 1'b0)
    `CHK("rst_busy", busy_a, 1'b0)
    `CHK("rst_ready", req_ready_a, 1'b1)
    `CHK("rst_ready_b", req_ready_b, 1'b1)
    viol_a = 0;
    bad_b  = 0;

    // Directed frame 0x84A5
    start(7'h04, 8'hA5, 1'b0);
    finish_check(model(7'h04, 8'hA5));
    `CHK("frame_84a5", rx_a, 16'h84A5)

    // Held valid: second request accepted right as ready returns
    start(7'h00, 8'h11, 1'b1);
    req_addr = 7'h02;
    req_data = 8'hFF;
    finish_check(model(7'h00, 8'h11));
    prev_rise = rise_cyc_a;
    start(7'h02, 8'hFF, 1'b0);
    `CHK("ncs_gap", (fall_cyc_a - prev_rise) >= Gap, 1'b1)
    finish_check(model(7'h02, 8'hFF));

    // Request raised mid-frame is ignored until the gap ends
    start(7'h01, 8'h3C, 1'b0);
    n = 0;
    while (rises_a < 9 && n < 1000) begin
      step();
      n++;
    end
    `CHK("mid_wait", rises_a >= 9, 1'b1)
    req_addr  = 7'h03;
    req_data  = 8'hC3;
    req_valid = 1'b1;
    finish_check(model(7'h01, 8'h3C));
    start(7'h03, 8'hC3, 1'b0);
    finish_check(model(7'h03, 8'hC3));

    // Random frames
    for (int i = 0; i < 3; i++) begin
      a = 7'($urandom);
      d = 8'($urandom);
      start(a, d, 1'b0);
      finish_check(model(a, d));
    end

    // Reset mid-shift
    a = 7'($urandom);
    d = 8'($urandom);
    start(a, d, 1'b0);
    n = 0;
    while (rises_a < 7 && n < 1000) begin
      step();
      n++;
    end
    `CHK("abort_wait", rises_a >= 7, 1'b1)
    rst = 1'b1;
    step();
    `CHK("abort_ncs", ncs_a, 1'b1)
    `CHK("abort_sclk", sclk_a, 1'b0)
    `CHK("abort_copi", copi_a, 1'b0)
    `CHK("abort_busy", busy_a, 1'b0)
    rst = 1'b0;
    repeat (20) step();
    `CHK("abort_no_done", dones_a, 0)
    `CHK("abort_ready", req_ready_a, 1'b1)

    // Recovery after abort
    start(7'h05, 8'h5A, 1'b0);
    finish_check(model(7'h05, 8'h5A));
    `CHK("copi_stable", viol_a, 0)

    // CLK_DIV=2 instance
    a = 7'($urandom);
    d = 8'($urandom);
    req_addr    = a;
    req_data    = d;
    req_valid_b = 1'b1;
    n = 0;
    while (!req_ready_b && n < 1000) begin
      step();
      n++;
    end
    `CHK("b_accept_wait", req_ready_b, 1'b1)
    t0b     = cyc;
    rx_b    = '0;
    rises_b = 0;
    step();
    req_valid_b = 1'b0;
    n = 0;
    while (!req_ready_b && n < 1000) begin
      step();
      n++;
    end
    `CHK("b_ready_wait", req_ready_b, 1'b1)
    `CHK("b_frame", rx_b, model(a, d))
    `CHK("b_rises", rises_b, 16)
    `CHK("b_ncs_rise_cycle", rise_cyc_b - t0b, NcsRiseB)
    `CHK("b_phase_len", bad_b, 0)

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
